// File: rtl/dacm_avg.sv
// Per-channel windowed averager for dacmux conversion results, with a watched-channel threshold compare.
// Define DACM_AVG_WIN8_EN for an 8-sample window; the default build averages 4 samples.
module dacm_avg #(
  parameter int DATA_W = 10
) (
  input  logic              mclk,
  input  logic              srst,
  input  logic              smp_vld,
  input  logic [3:0]        smp_ch,
  input  logic [DATA_W-1:0] smp_dat,
  input  logic              smp_10b,
  input  logic              flush,
  input  logic [3:0]        wch,
  input  logic [DATA_W-1:0] thr_hi,
  input  logic [DATA_W-1:0] thr_lo,
  input  logic [1:0]        irq_clr,
  input  logic [3:0]        rd_ch,
  output logic [DATA_W-1:0] rd_avg,
  output logic              avg_vld,
  output logic [3:0]        avg_ch,
  output logic [DATA_W-1:0] avg_dat,
  output logic              busy,
  output logic              irq_hi,
  output logic              irq_lo,
  output logic              ovr
);

  localparam int NCH   = 16;
  localparam int ACC_W = 13;
  localparam int CNT_W = 3;
`ifdef DACM_AVG_WIN8_EN
  localparam int WIN   = 8;
  localparam int SHIFT = 3;
`else
  localparam int WIN   = 4;
  localparam int SHIFT = 2;
`endif

  typedef enum logic [1:0] {IDLE, ACC, CMP} state_t;

  state_t state, state_nxt;

  logic [ACC_W-1:0]  acc  [NCH];
  logic [CNT_W-1:0]  cnt  [NCH];
  logic [DATA_W-1:0] lavg [NCH];

  logic [3:0]        ch_p0;
  logic [DATA_W-1:0] dat_p0;
  logic [DATA_W-1:0] avg_p1;

  logic [ACC_W-1:0]  sum;
  logic [DATA_W-1:0] sum_avg;
  logic              last;
  logic              take;
  logic              cmp_act;
  logic              hi_set;
  logic              lo_set;

  // 8-bit results are scaled to the 10-bit range so both modes share one accumulator
  function automatic logic [DATA_W-1:0] norm(input logic [DATA_W-1:0] d, input logic b10);
    return b10 ? d : {d[7:0], 2'b00};
  endfunction

  function automatic logic [DATA_W-1:0] win_avg(input logic [ACC_W-1:0] s);
    return DATA_W'(s >> SHIFT);
  endfunction

  assign take    = (state == IDLE) && smp_vld && !flush;
  assign sum     = acc[ch_p0] + {{(ACC_W-DATA_W){1'b0}}, dat_p0};
  assign sum_avg = win_avg(sum);
  assign last    = (cnt[ch_p0] == CNT_W'(WIN-1));
  assign cmp_act = (state == CMP) && !flush && !srst;
  assign hi_set  = cmp_act && (ch_p0 == wch) && (avg_p1 > thr_hi);
  assign lo_set  = cmp_act && (ch_p0 == wch) && (avg_p1 < thr_lo);

  assign busy    = (state != IDLE) && !srst;
  assign avg_vld = cmp_act;
  assign avg_ch  = cmp_act ? ch_p0  : '0;
  assign avg_dat = cmp_act ? avg_p1 : '0;
  assign rd_avg  = srst ? '0 : lavg[rd_ch];

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (take) state_nxt = ACC;
      ACC:  state_nxt = (!flush && last) ? CMP : IDLE;
      CMP:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge mclk) begin
    if (srst) begin
      state  <= IDLE;
      ch_p0  <= '0;
      dat_p0 <= '0;
      avg_p1 <= '0;
      irq_hi <= 1'b0;
      irq_lo <= 1'b0;
      ovr    <= 1'b0;
      for (int i = 0; i < NCH; i++) begin
        acc[i]  <= '0;
        cnt[i]  <= '0;
        lavg[i] <= '0;
      end
    end else begin
      state <= state_nxt;
      // stage p0: capture the incoming sample
      if (take) begin
        ch_p0  <= smp_ch;
        dat_p0 <= norm(smp_dat, smp_10b);
      end
      // stage p1: accumulate; the window's last sample produces the average
      if (flush) begin
        ovr <= 1'b0;
        for (int i = 0; i < NCH; i++) begin
          acc[i] <= '0;
          cnt[i] <= '0;
        end
      end else begin
        if (busy && smp_vld) ovr <= 1'b1;
        if (state == ACC) begin
          if (last) begin
            acc[ch_p0]  <= '0;
            cnt[ch_p0]  <= '0;
            lavg[ch_p0] <= sum_avg;
            avg_p1      <= sum_avg;
          end else begin
            acc[ch_p0] <= sum;
            cnt[ch_p0] <= cnt[ch_p0] + CNT_W'(1);
          end
        end
      end
      // stage p2: threshold compare; a set beats a same-cycle clear
      irq_hi <= hi_set | (irq_hi & ~irq_clr[1]);
      irq_lo <= lo_set | (irq_lo & ~irq_clr[0]);
    end
  end

endmodule

// File: tb/tb_dacm_avg.sv
// Directed self-checking bench for dacm_avg: averaging, thresholds, overrun, flush and reset.
module tb_dacm_avg;
`ifdef DACM_AVG_WIN8_EN
  localparam int W = 8;
`else
  localparam int W = 4;
`endif

  logic       mclk = 1'b0;
  logic       srst, smp_vld, smp_10b, flush, avg_vld, busy, irq_hi, irq_lo, ovr;
  logic [3:0] smp_ch, wch, rd_ch, avg_ch;
  logic [9:0] smp_dat, thr_hi, thr_lo, rd_avg, avg_dat;
  logic [1:0] irq_clr;

  int nchk = 0;
  int nerr = 0;

  dacm_avg dut (
    .mclk(mclk), .srst(srst), .smp_vld(smp_vld), .smp_ch(smp_ch), .smp_dat(smp_dat),
    .smp_10b(smp_10b), .flush(flush), .wch(wch), .thr_hi(thr_hi), .thr_lo(thr_lo),
    .irq_clr(irq_clr), .rd_ch(rd_ch), .rd_avg(rd_avg), .avg_vld(avg_vld), .avg_ch(avg_ch),
    .avg_dat(avg_dat), .busy(busy), .irq_hi(irq_hi), .irq_lo(irq_lo), .ovr(ovr)
  );

  always #5 mclk = ~mclk;

  task automatic tick();
    @(posedge mclk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // one strobe, then one cycle of processing; returns with avg_vld visible if it completed a window
  task automatic feed(input logic [3:0] ch, input logic [9:0] d, input logic b10);
    smp_vld = 1'b1; smp_ch = ch; smp_dat = d; smp_10b = b10;
    tick();
    smp_vld = 1'b0;
    tick();
  endtask

  // a full window of identical samples; checks the result and leaves CMP with irq_clr = clr
  task automatic feed_w(input string tag, input logic [3:0] ch, input logic [9:0] d,
                        input logic b10, input logic [9:0] exp, input logic [1:0] clr);
    for (int i = 0; i < W - 1; i++) feed(ch, d, b10);
    chk({tag, "_early_vld"}, 32'(avg_vld), 0);
    feed(ch, d, b10);
    chk({tag, "_vld"}, 32'(avg_vld), 1);
    chk({tag, "_ch"},  32'(avg_ch),  32'(ch));
    chk({tag, "_dat"}, 32'(avg_dat), 32'(exp));
    irq_clr = clr;
    tick();
    irq_clr = 2'b00;
  endtask

  initial begin
    logic [9:0] seq [4];
    seq[0] = 10'd100; seq[1] = 10'd101; seq[2] = 10'd102; seq[3] = 10'd104;

    srst = 1'b1; smp_vld = 1'b0; smp_ch = '0; smp_dat = '0; smp_10b = 1'b1; flush = 1'b0;
    wch = 4'd5; thr_hi = 10'd500; thr_lo = 10'd100; irq_clr = 2'b00; rd_ch = 4'd0;
    tick(); tick();
    srst = 1'b0;
    chk("rst_avg_vld", 32'(avg_vld), 0);
    chk("rst_avg_ch",  32'(avg_ch),  0);
    chk("rst_avg_dat", 32'(avg_dat), 0);
    chk("rst_busy",    32'(busy),    0);
    chk("rst_rd_avg",  32'(rd_avg),  0);
    chk("rst_flags",   32'({irq_hi, irq_lo, ovr}), 0);

    // channel 3, 10-bit: floor(407/4) = 101
    for (int r = 0; r < W / 4; r++) begin
      for (int i = 0; i < 4; i++) begin
        smp_vld = 1'b1; smp_ch = 4'd3; smp_dat = seq[i]; smp_10b = 1'b1;
        tick();
        smp_vld = 1'b0;
        chk("c3_busy", 32'(busy), 1);
        tick();
        if (r == W / 4 - 1 && i == 3) begin
          chk("c3_vld", 32'(avg_vld), 1);
          chk("c3_ch",  32'(avg_ch),  3);
          chk("c3_dat", 32'(avg_dat), 101);
        end else begin
          chk("c3_novld", 32'(avg_vld), 0);
        end
      end
    end
    tick();
    chk("c3_single_pulse", 32'(avg_vld), 0);
    rd_ch = 4'd3; #1;
    chk("c3_rd_avg", 32'(rd_avg), 101);

    // channel 0, 8-bit 0xFF normalises to 1020; upper data bits are ignored
    feed_w("c0_8b", 4'd0, 10'h3FF, 1'b0, 10'd1020, 2'b00);
    rd_ch = 4'd0; #1;
    chk("c0_rd_avg", 32'(rd_avg), 1020);

    // thresholds on watched channel 5
    feed_w("t501", 4'd5, 10'd501, 1'b1, 10'd501, 2'b00);
    chk("t501_hi", 32'(irq_hi), 1);
    chk("t501_lo", 32'(irq_lo), 0);
    irq_clr = 2'b10; tick(); irq_clr = 2'b00;
    chk("hi_cleared", 32'(irq_hi), 0);
    feed_w("t500", 4'd5, 10'd500, 1'b1, 10'd500, 2'b00);
    chk("t500_flags", 32'({irq_hi, irq_lo}), 0);
    feed_w("t099", 4'd5, 10'd99, 1'b1, 10'd99, 2'b11);
    chk("t099_lo_set_wins", 32'(irq_lo), 1);
    chk("t099_hi", 32'(irq_hi), 0);
    irq_clr = 2'b01; tick(); irq_clr = 2'b00;
    chk("lo_cleared", 32'(irq_lo), 0);
    feed_w("unwatched", 4'd6, 10'd900, 1'b1, 10'd900, 2'b00);
    chk("unwatched_flags", 32'({irq_hi, irq_lo}), 0);
    thr_hi = 10'd50; thr_lo = 10'd900;
    feed_w("both", 4'd5, 10'd99, 1'b1, 10'd99, 2'b00);
    chk("both_flags", 32'({irq_hi, irq_lo}), 3);
    irq_clr = 2'b11; tick(); irq_clr = 2'b00;
    thr_hi = 10'd500; thr_lo = 10'd100;

    // overrun: ch1 strobe one cycle after ch2
    smp_vld = 1'b1; smp_ch = 4'd2; smp_dat = 10'd40; smp_10b = 1'b1;
    tick();
    smp_ch = 4'd1; smp_dat = 10'd999;
    tick();
    smp_vld = 1'b0;
    chk("ovr_set", 32'(ovr), 1);
    for (int i = 0; i < W - 2; i++) feed(4'd2, 10'd40, 1'b1);
    feed(4'd2, 10'd40, 1'b1);
    chk("ovr_c2_vld", 32'(avg_vld), 1);
    chk("ovr_c2_dat", 32'(avg_dat), 40);
    tick();
    rd_ch = 4'd1; #1;
    chk("ovr_c1_untouched", 32'(rd_avg), 0);
    chk("ovr_sticky", 32'(ovr), 1);

    // flush discards the two partial ch7 samples and clears ovr
    feed(4'd7, 10'd1000, 1'b1);
    feed(4'd7, 10'd1000, 1'b1);
    flush = 1'b1; tick(); flush = 1'b0;
    chk("flush_ovr", 32'(ovr), 0);
    feed_w("c7_flush", 4'd7, 10'd200, 1'b1, 10'd200, 2'b00);
    flush = 1'b1; smp_vld = 1'b1; smp_ch = 4'd7; smp_dat = 10'd10;
    tick();
    flush = 1'b0; smp_vld = 1'b0;
    chk("flush_vld_busy", 32'(busy), 0);
    chk("flush_vld_ovr", 32'(ovr), 0);
    smp_vld = 1'b1; smp_ch = 4'd8; smp_dat = 10'd300;
    tick();
    smp_vld = 1'b0; flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush_acc_busy", 32'(busy), 0);
    chk("flush_acc_vld", 32'(avg_vld), 0);
    rd_ch = 4'd7; #1;
    chk("flush_keeps_lavg", 32'(rd_avg), 200);

    // reset while in ACC discards the sample and clears everything
    smp_vld = 1'b1; smp_ch = 4'd9; smp_dat = 10'd77;
    tick();
    smp_vld = 1'b0; srst = 1'b1; rd_ch = 4'd3; #1;
    chk("srst_during_busy", 32'(busy), 0);
    chk("srst_during_rd",   32'(rd_avg), 0);
    tick();
    srst = 1'b0;
    chk("srst_vld",   32'(avg_vld), 0);
    chk("srst_outs",  32'({avg_ch, avg_dat, busy}), 0);
    chk("srst_rd",    32'(rd_avg), 0);
    tick();
    chk("srst_no_late_vld", 32'(avg_vld), 0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
